// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkg
//  Brief    : Shared constants, FSM encodings and divider helper for the UART.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Clocks per oversample tick, rounded down; callers must keep this >= 2.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : baud_tick_gen
//  Brief    : Free-running oversample tick divider with synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV     = calc_div(CLK_HZ, BAUD);
    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TOP = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_TOP)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_TOP);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 UART receiver, 16x oversampled, mid-bit sampling with
//             start-glitch rejection and stop-bit framing check.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dato,
    output logic       bandera,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [3:0] c_TICK_MID  = 4'd7;
    localparam logic [3:0] c_TICK_LAST = 4'd15;
    localparam logic [2:0] c_BIT_LAST  = 3'd7;

    logic       r_rx_meta;
    logic       r_rx_s;
    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shreg;
    logic       r_armed;
    logic [7:0] r_dato;
    logic       r_bandera;
    logic       r_rx_done;
    logic       r_frame_err;

    logic       w_tick;
    logic       w_clr;
    logic       w_mid;
    logic       w_bit_end;
    logic       w_shift;
    logic       w_good;
    logic       w_bad;
    logic       w_busy;

    baud_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s && r_armed) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_mid) begin
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == c_BIT_LAST)) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_clr     = (r_state == S_IDLE) && !r_rx_s && r_armed;
        w_mid     = (r_state == S_START) && w_tick && (r_tick_cnt == c_TICK_MID);
        w_bit_end = w_tick && (r_tick_cnt == c_TICK_LAST);
        w_shift   = (r_state == S_DATA) && w_bit_end;
        w_good    = (r_state == S_STOP) && w_bit_end && r_rx_s;
        w_bad     = (r_state == S_STOP) && w_bit_end && !r_rx_s;
    end

    // tick_cnt and bit_cnt wrap naturally at 15 and 7, so no explicit reload
    // is needed between data bits or entering STOP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
        end else begin
            if (w_clr || w_mid) begin
                r_tick_cnt <= '0;
            end else if (w_busy && w_tick) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            if (w_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_shift) begin
                r_shreg <= {r_rx_s, r_shreg[7:1]};
            end
        end
    end

    // After a framing error the line must be seen idle before re-arming,
    // otherwise a held break would retrigger START forever.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_armed     <= 1'b1;
            r_dato      <= 8'h00;
            r_bandera   <= 1'b0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done   <= w_good;
            r_frame_err <= w_bad;

            if (w_bad) begin
                r_armed <= 1'b0;
            end else if ((r_state == S_IDLE) && r_rx_s) begin
                r_armed <= 1'b1;
            end

            if (w_good) begin
                r_dato    <= r_shreg;
                r_bandera <= 1'b1;
            end else if (w_bad) begin
                r_bandera <= 1'b0;
            end
        end
    end

    assign dato      = r_dato;
    assign bandera   = r_bandera;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Self-checking bench for uart_rx with directed and random frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_CLK_HZ = 1_536_000;
    localparam int c_BAUD   = 9600;
    localparam int c_BIT    = 160;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] dato;
    logic       bandera;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int d0;
    int f0;

    logic [7:0] exp_dato;
    logic       exp_band;

    uart_rx #(
        .CLK_HZ (c_CLK_HZ),
        .BAUD   (c_BAUD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .dato      (dato),
        .bandera   (bandera),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done)              done_cnt++;
        if (frame_err)            ferr_cnt++;
        if (rx_done && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (c_BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    // Reference: a good stop bit publishes the byte and raises bandera; a bad
    // one pulses frame_err, drops bandera and leaves dato alone.
    task automatic frame_and_check(input string tag, input logic [7:0] b,
                                   input logic stop_bit, input int gap);
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(b, stop_bit);
        rx = 1'b1;
        repeat (gap + 4) @(negedge clk);
        if (stop_bit) begin
            exp_dato = b;
            exp_band = 1'b1;
        end else begin
            exp_band = 1'b0;
        end
        check({tag, "_done"}, done_cnt - d0, stop_bit ? 1 : 0);
        check({tag, "_ferr"}, ferr_cnt - f0, stop_bit ? 0 : 1);
        check({tag, "_dato"}, dato, exp_dato);
        check({tag, "_band"}, bandera, exp_band);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dato", dato, 8'h00);
        check("rst_band", bandera, 0);
        check("rst_done", rx_done, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        rst_n    = 1'b1;
        exp_dato = 8'h00;
        exp_band = 1'b0;
        repeat (20) @(negedge clk);

        fork
            frame_and_check("f35", 8'h35, 1'b1, 20);
            begin
                repeat (400) @(negedge clk);
                check("busy_mid", busy, 1);
            end
        join

        d0 = done_cnt;
        send_frame(8'hA7, 1'b1);
        check("b2b_first", dato, 8'hA7);
        send_frame(8'h0F, 1'b1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_dato", dato, 8'h0F);
        check("b2b_band", bandera, 1);
        exp_dato = 8'h0F;
        exp_band = 1'b1;
        repeat (30) @(negedge clk);

        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_dato", dato, exp_dato);
        check("glitch_busy", busy, 0);

        frame_and_check("ferr5a", 8'h5A, 1'b0, 20);

        d0 = done_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * c_BIT + c_BIT / 2) @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("mrst_done", done_cnt - d0, 0);
        check("mrst_dato", dato, 8'h00);
        check("mrst_band", bandera, 0);
        exp_dato = 8'h00;
        exp_band = 1'b0;

        frame_and_check("f81", 8'h81, 1'b1, 10);

        for (int k = 0; k < 14; k++) begin
            logic [7:0] b;
            logic       sb;
            b  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 3) != 0);
            frame_and_check("rnd", b, sb, int'($urandom_range(0, 60)));
        end

        check("exclusive", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
